dds_sample_sequencer: RTL
=========================

// Module: dds_sample_sequencer
// PURPOSE
//  Direct-digital-synthesis controller that sequences 14-bit offset-binary sine samples into
//  offsetBinary_to_2sComplement ahead of the DAC. Phase accumulator, quarter-wave LUT lookup,
//  start/stop FSM, glitch-free frequency retune via valid/ready handshake applied at phase wrap.
// PARAMETERS
//  PHASE_W      32           phase accumulator width (bits)
//  LUT_AW       8            quarter-wave LUT address width (2^LUT_AW entries)
//  DEFAULT_FTW  32'h0100_0000 frequency tuning word loaded at reset
// PORTS
//  clk          in   1        system clock, all logic rising-edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        pulse: IDLE->RUN
//  stop         in   1        pulse: RUN->DRAIN
//  cfg_valid    in   1        new tuning word offered
//  cfg_ready    out  1        tuning word can be accepted
//  cfg_ftw      in   PHASE_W  tuning word, sampled when cfg_valid&&cfg_ready
//  cfg_amp      in   8        amplitude scale (AMPLITUDE_SCALE_EN only)
//  busy         out  1        FSM not IDLE
//  sample_valid out  1        offset_out holds a new sample this cycle
//  offset_out   out  14       offset-binary sample to converter, midscale 14'h2000
//  phase_wrap   out  1        1-cycle pulse on accumulator carry-out
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, ftw=DEFAULT_FTW, pending=0; cfg_ready=1, busy=0,
//   sample_valid=0, phase_wrap=0, offset_out=14'h2000.
//  FSM IDLE: acc held 0, offset_out=14'h2000, sample_valid=0. start -> RUN. stop ignored;
//   start&&stop together -> RUN.
//  RUN: acc<=acc+ftw every cycle (mod 2^PHASE_W). stop -> DRAIN; start ignored; both -> DRAIN.
//  DRAIN: keeps accumulating; on carry-out acc forced to 0, -> IDLE (waveform ends at phase 0).
//   start in DRAIN ignored.
//  phase_wrap=1 the cycle after an add produces carry-out (RUN or DRAIN).
//  Lookup: addr=acc[PHASE_W-1 -: LUT_AW+2]; q=addr[top 2], idx=addr[LUT_AW-1:0].
//   q0: mag=LUT[idx]; q1: LUT[~idx]; q2: -LUT[idx]; q3: -LUT[~idx]. LUT 13-bit, 0..8191.
//   sample = 8192+mag (clamp to 16383) / 8192-mag (q2,q3). No wrap-around past 0/16383.
//  Latency: 2 cycles acc->offset_out (registered LUT read, registered output stage).
//   sample_valid follows the 2-stage pipeline of the RUN/DRAIN qualifier; first valid
//   2 cycles after entering RUN; last valid 2 cycles after the DRAIN wrap, carrying phase 0.
//  Retune: accept when cfg_valid&&cfg_ready -> pending=1, cfg_ready=0. IDLE: ftw<=pending
//   word next cycle. RUN/DRAIN: ftw updated only on the add producing carry-out, so new
//   frequency starts at phase 0. pending clears then; cfg_ready=1 following cycle.
//   cfg_ftw=0 is legal: acc frozen; DRAIN then never wraps until a nonzero ftw retunes
//   (no timeout).
//  rst mid-operation: immediate return to reset values; pending word discarded.
// CONFIGURATION
//  AMPLITUDE_SCALE_EN defined: mag_scaled = (mag*cfg_amp)>>8, cfg_amp registered at start
//   and at each wrap; adds one pipeline stage (latency 3). cfg_amp=0 -> constant 14'h2000.
//  Undefined: cfg_amp port absent, full-scale magnitude, latency 2.
// STRUCTURE
//  Package dds_pkg: PHASE_W/LUT_AW defaults, MIDSCALE=14'h2000, FSM enum
//   {IDLE,RUN,DRAIN}, quadrant localparams.
//  Sub-module sine_quarter_lut: registered ROM, LUT_AW address in, 13-bit magnitude out,
//   contents round(8191*sin((i+0.5)*pi/2^(LUT_AW+1))).
// TESTING
//  1 rst held 3 cycles then released, no start -> offset_out=14'h2000, sample_valid=0,
//    cfg_ready=1 indefinitely.
//  2 ftw=32'h0100_0000, start -> first valid at cycle+2, phase_wrap every 256 cycles,
//    samples symmetric about 8192, peak 8192+LUT[255] in q0/q1, never >16383.
//  3 In RUN at acc=32'h4000_0000 offer cfg_ftw=32'h0200_0000 -> cfg_ready=0, old rate until
//    wrap, then 128-cycle period; cfg_ready=1 one cycle after wrap.
//  4 stop mid-period -> DRAIN, samples continue to wrap, last valid sample 14'h2000 at
//    phase 0, busy=0 after; start during DRAIN has no effect.
//  5 start&&stop same cycle in IDLE -> RUN; in RUN -> DRAIN; rst during DRAIN with pending
//    retune -> all reset values next cycle, ftw=DEFAULT_FTW.
//  6 AMPLITUDE_SCALE_EN, cfg_amp=8'h80 -> peak excursion halved (±~4095), latency 3;
//    cfg_amp=0 -> constant 14'h2000 with sample_valid still pulsing.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants, FSM encoding and sample-forming helpers for the
// DDS sample sequencer (phase -> quadrant -> offset-binary sample).
package dds_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int LUT_AW_DEF  = 8;
    localparam int SAMPLE_W    = 14;
    localparam int MAG_W       = 13;

    localparam logic [SAMPLE_W-1:0] MIDSCALE  = 14'h2000;
    localparam logic [SAMPLE_W-1:0] FULLSCALE = 14'h3FFF;

    localparam logic [1:0] QUAD0 = 2'd0;
    localparam logic [1:0] QUAD1 = 2'd1;
    localparam logic [1:0] QUAD2 = 2'd2;
    localparam logic [1:0] QUAD3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dds_state_e;

    // Quadrants 1 and 3 walk the quarter wave backwards.
    function automatic logic quad_mirrors(input logic [1:0] q);
        logic m;
        m = 1'b0;
        unique case (q)
            QUAD0, QUAD2: m = 1'b0;
            QUAD1, QUAD3: m = 1'b1;
            default:      m = 1'b0;
        endcase
        return m;
    endfunction

    // Quadrants 2 and 3 are the negative half-cycle.
    function automatic logic quad_negates(input logic [1:0] q);
        logic n;
        n = 1'b0;
        unique case (q)
            QUAD0, QUAD1: n = 1'b0;
            QUAD2, QUAD3: n = 1'b1;
            default:      n = 1'b0;
        endcase
        return n;
    endfunction

    // Offset-binary sample around midscale, saturating at full scale.
    function automatic logic [SAMPLE_W-1:0] mag_to_offset(
        input logic [1:0]       q,
        input logic [MAG_W-1:0] mag
    );
        logic [SAMPLE_W:0]   up;
        logic [SAMPLE_W-1:0] s;
        up = {1'b0, MIDSCALE} + {2'b00, mag};
        if (quad_negates(q)) begin
            s = MIDSCALE - {1'b0, mag};
        end else if (up > {1'b0, FULLSCALE}) begin
            s = FULLSCALE;
        end else begin
            s = up[SAMPLE_W-1:0];
        end
        return s;
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave sine ROM.
// Ports: clk; addr (LUT_AW) in; mag (13-bit, 0..8191) out one cycle later.
module sine_quarter_lut
    import dds_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [MAG_W-1:0]  mag
);

    localparam int DEPTH = 1 << LUT_AW;

    // round(8191*sin((i+0.5)*pi/(2*DEPTH))); the half-step offset keeps
    // the table symmetric so mirrored quadrants join without a repeat.
    function automatic logic [MAG_W-1:0] entry(input int i);
        real x;
        real term;
        real s;
        x    = (real'(i) + 0.5) * 3.14159265358979323846 / real'(2 * DEPTH);
        term = x;
        s    = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return MAG_W'($rtoi(8191.0 * s + 0.5));
    endfunction

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = entry(i);
    end

    always_ff @(posedge clk) begin
        mag <= rom[addr];
    end

endmodule

// File: rtl/dds_sample_sequencer.sv
// DDS controller: phase accumulator, quarter-wave lookup, start/stop/drain
// FSM and wrap-aligned frequency retune, feeding 14-bit offset-binary samples.
// Ports: clk, rst (sync, active-high); start/stop pulses; cfg_valid/
// cfg_ready/cfg_ftw retune handshake; cfg_amp (AMPLITUDE_SCALE_EN only);
// busy, sample_valid, offset_out, phase_wrap.
// Build option: AMPLITUDE_SCALE_EN adds amplitude scaling (+1 latency).
module dds_sample_sequencer
    import dds_pkg::*;
#(
    parameter int                 PHASE_W     = PHASE_W_DEF,
    parameter int                 LUT_AW      = LUT_AW_DEF,
    parameter logic [PHASE_W-1:0] DEFAULT_FTW = PHASE_W'(32'h0100_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PHASE_W-1:0]  cfg_ftw,
`ifdef AMPLITUDE_SCALE_EN
    input  logic [7:0]          cfg_amp,
`endif
    output logic                busy,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] offset_out,
    output logic                phase_wrap
);

    dds_state_e state;
    dds_state_e state_nxt;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] pend_ftw;
    logic [PHASE_W-1:0] sum;
    logic               carry;
    logic               pending;
    logic               live;
    logic               active;
    logic               apply_ftw;

    assign {carry, sum} = {1'b0, acc} + {1'b0, ftw};
    assign active       = (state != IDLE);
    assign busy         = active;
    assign cfg_ready    = !pending;

    // A frozen accumulator (ftw==0) never wraps, so a waiting word is
    // taken at once; otherwise it waits for the carry so the new
    // frequency begins at phase 0.
    assign apply_ftw = pending && (!active || carry || (ftw == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop)  state_nxt = DRAIN;
            DRAIN:   if (carry) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // live marks acc as holding a sample to emit; it stays set for the
    // phase-0 cycle that follows the drain wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            ftw        <= DEFAULT_FTW;
            pend_ftw   <= '0;
            pending    <= 1'b0;
            live       <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            phase_wrap <= active && carry;
            live       <= active || start;
            if ((state == RUN) || ((state == DRAIN) && !carry)) begin
                acc <= sum;
            end else begin
                acc <= '0;
            end
            if (apply_ftw) begin
                ftw     <= pend_ftw;
                pending <= 1'b0;
            end else if (cfg_valid && !pending) begin
                pend_ftw <= cfg_ftw;
                pending  <= 1'b1;
            end
        end
    end

    logic [LUT_AW+1:0]  addr;
    logic [1:0]         quad0;
    logic [LUT_AW-1:0]  idx;
    logic [LUT_AW-1:0]  lut_addr;
    logic [MAG_W-1:0]   lut_mag;

    assign addr     = acc[PHASE_W-1 -: LUT_AW+2];
    assign quad0    = addr[LUT_AW+1:LUT_AW];
    assign idx      = addr[LUT_AW-1:0];
    assign lut_addr = quad_mirrors(quad0) ? ~idx : idx;

    sine_quarter_lut #(
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .mag  (lut_mag)
    );

    logic [1:0] quad1;
    logic       v1;
    logic       last1;

    // last1 tags the post-drain phase-0 sample, which is emitted as
    // exact midscale so the waveform parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            quad1 <= QUAD0;
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            quad1 <= quad0;
            v1    <= live;
            last1 <= live && !active;
        end
    end

    logic [MAG_W-1:0] mag2;
    logic [1:0]       quad2;
    logic             v2;
    logic             last2;

`ifdef AMPLITUDE_SCALE_EN
    logic [7:0]         amp_r;
    logic [MAG_W+7:0]   prod;

    assign prod = (MAG_W+8)'(lut_mag) * (MAG_W+8)'(amp_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            amp_r <= '0;
            mag2  <= '0;
            quad2 <= QUAD0;
            v2    <= 1'b0;
            last2 <= 1'b0;
        end else begin
            if (((state == IDLE) && start) || (active && carry)) begin
                amp_r <= cfg_amp;
            end
            mag2  <= MAG_W'(prod >> 8);
            quad2 <= quad1;
            v2    <= v1;
            last2 <= last1;
        end
    end
`else
    assign mag2  = lut_mag;
    assign quad2 = quad1;
    assign v2    = v1;
    assign last2 = last1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            offset_out   <= MIDSCALE;
        end else begin
            sample_valid <= v2;
            if (v2 && !last2) begin
                offset_out <= mag_to_offset(quad2, mag2);
            end else begin
                offset_out <= MIDSCALE;
            end
        end
    end

endmodule
